// File: rtl/pipe_stage_hs_if.sv
// Stream channel carried between pipeline stages: valid/ready handshake
// plus the instruction word, opaque payload and control-bit vector.
`timescale 1ns/1ps
interface pipe_stage_hs_if #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 8
);
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
    logic [CTRL_W-1:0]  ctrl;

    // Producer side drives the entry, consumer side answers with ready.
    modport master (output valid, output instr, output data, output ctrl, input ready);
    modport slave  (input valid, input instr, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_hs.sv
// Single pipeline stage with valid/ready handshake, optional two-entry skid
// buffer, NOP bubble injection, synchronous flush and a saturating bubble count.
`timescale 1ns/1ps
module pipe_stage_hs #(
    parameter int                 INSTR_W   = 16,
    parameter int                 DATA_W    = 128,
    parameter int                 CTRL_W    = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter int                 SKID      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_hs_if.slave       upstream,
    pipe_stage_hs_if.master      downstream,
    input  logic                 bubble,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [15:0]          stat_bubbles
);

    logic               ready_en;
    logic               head_valid;
    logic [INSTR_W-1:0] head_instr;
    logic [DATA_W-1:0]  head_data;
    logic [CTRL_W-1:0]  head_ctrl;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  skid_ctrl;

    logic               space;
    logic               enq;
    logic               deq;
    logic [INSTR_W-1:0] enq_instr;
    logic [DATA_W-1:0]  enq_data;
    logic [CTRL_W-1:0]  enq_ctrl;

    // Space/enqueue/dequeue decisions and the entry to write (bubble or upstream).
    always_comb begin
        deq = head_valid & downstream.ready;
        if (SKID != 0) begin
            space = ready_en & !(head_valid & skid_valid);
        end else begin
            space = ready_en & (!head_valid | downstream.ready);
        end
        enq       = !flush & space & (bubble | upstream.valid);
        enq_instr = bubble ? NOP_INSTR : upstream.instr;
        enq_ctrl  = bubble ? '0 : upstream.ctrl;
        enq_data  = upstream.data;
    end

    assign upstream.ready   = !bubble & !flush & space;
    assign downstream.valid = head_valid;
    assign downstream.instr = head_instr;
    assign downstream.data  = head_data;
    assign downstream.ctrl  = head_ctrl;
    assign occupancy        = {1'b0, head_valid} + {1'b0, skid_valid};

    // Holds in_ready low until the first clock after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    // Head/skid storage: flush clears everything, otherwise FIFO refill of the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_valid <= 1'b0;
            head_instr <= NOP_INSTR;
            head_data  <= '0;
            head_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            head_instr <= NOP_INSTR;
            head_data  <= '0;
            head_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (deq && skid_valid) begin
            head_valid <= 1'b1;
            head_instr <= skid_instr;
            head_data  <= skid_data;
            head_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
        end else if (enq && (!head_valid || deq)) begin
            head_valid <= 1'b1;
            head_instr <= enq_instr;
            head_data  <= enq_data;
            head_ctrl  <= enq_ctrl;
        end else if (enq) begin
            skid_valid <= 1'b1;
            skid_instr <= enq_instr;
            skid_data  <= enq_data;
            skid_ctrl  <= enq_ctrl;
        end else if (deq) begin
            head_valid <= 1'b0;
        end
    end

    // Counts bubbles that actually found space; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_bubbles <= 16'd0;
        end else if (enq && bubble && (stat_bubbles != 16'hFFFF)) begin
            stat_bubbles <= stat_bubbles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Testbench for pipe_stage_hs: drives a SKID=1 and a SKID=0 instance with the
// same stimulus and checks directed scenarios plus a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_stage_hs;

    typedef struct packed {
        logic [15:0]  instr;
        logic [127:0] data;
        logic [7:0]   ctrl;
    } entry_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [15:0]  in_instr;
    logic [127:0] in_data;
    logic [7:0]   in_ctrl;
    logic         bubble;
    logic         flush;
    logic         out_ready;
    logic [1:0]   occ1, occ0;
    logic [15:0]  stat1, stat0;

    int n_checks;
    int n_fail;

    entry_t mq [2][2];
    int     msz [2];
    int     mcnt [2];

    pipe_stage_hs_if #(.INSTR_W(16), .DATA_W(128), .CTRL_W(8)) up1 ();
    pipe_stage_hs_if #(.INSTR_W(16), .DATA_W(128), .CTRL_W(8)) dn1 ();
    pipe_stage_hs_if #(.INSTR_W(16), .DATA_W(128), .CTRL_W(8)) up0 ();
    pipe_stage_hs_if #(.INSTR_W(16), .DATA_W(128), .CTRL_W(8)) dn0 ();

    assign up1.valid = in_valid;
    assign up1.instr = in_instr;
    assign up1.data  = in_data;
    assign up1.ctrl  = in_ctrl;
    assign dn1.ready = out_ready;
    assign up0.valid = in_valid;
    assign up0.instr = in_instr;
    assign up0.data  = in_data;
    assign up0.ctrl  = in_ctrl;
    assign dn0.ready = out_ready;

    pipe_stage_hs #(.SKID(1)) dut1 (
        .clk(clk), .rst(rst), .upstream(up1), .downstream(dn1),
        .bubble(bubble), .flush(flush), .occupancy(occ1), .stat_bubbles(stat1)
    );

    pipe_stage_hs #(.SKID(0)) dut0 (
        .clk(clk), .rst(rst), .upstream(up0), .downstream(dn0),
        .bubble(bubble), .flush(flush), .occupancy(occ0), .stat_bubbles(stat0)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Time limit so a stuck run still reports.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = 16'h0; in_data = '0; in_ctrl = 8'h0;
        tick(); tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin msz[k] = 0; mcnt[k] = 0; end
    endtask

    function automatic bit m_space(int k);
        if (k == 1) return msz[1] < 2;
        return (msz[0] == 0) || out_ready;
    endfunction

    // Reference model: bounded FIFO of capacity 2 (skid) or 1 (plain register).
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit sp, dq, eq;
            entry_t e;
            sp = m_space(k);
            dq = (msz[k] > 0) && out_ready;
            eq = !flush && sp && (bubble || in_valid);
            e.instr = bubble ? 16'h0800 : in_instr;
            e.data  = in_data;
            e.ctrl  = bubble ? 8'h00 : in_ctrl;
            if (flush) begin
                msz[k] = 0;
            end else begin
                if (dq) begin mq[k][0] = mq[k][1]; msz[k] = msz[k] - 1; end
                if (eq) begin
                    mq[k][msz[k]] = e;
                    msz[k] = msz[k] + 1;
                    if (bubble && mcnt[k] < 65535) mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) begin
            in_valid = 1'($urandom); in_instr = 16'($urandom); in_data = {$urandom, $urandom, $urandom, $urandom};
            in_ctrl = 8'($urandom); bubble = 1'($urandom); flush = 1'($urandom); out_ready = 1'($urandom);
            tick();
        end
        n_checks++; if (dn1.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", dn1.valid); end
        n_checks++; if (dn1.instr !== 16'h0800) begin n_fail++; $display("[TB] FAIL reset_instr: got %h want 0800", dn1.instr); end
        n_checks++; if (dn1.ctrl !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h want 00", dn1.ctrl); end
        n_checks++; if (dn1.data !== 128'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", dn1.data); end
        n_checks++; if (occ1 !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_occ: got %0d want 0", occ1); end
        n_checks++; if (stat1 !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_stat: got %h want 0", stat1); end
        n_checks++; if (up1.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0", up1.ready); end
        n_checks++; if (dn0.valid !== 1'b0 || up0.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_skid0: got valid %b ready %b want 0 0", dn0.valid, up0.ready); end
        in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rst = 1'b1;
        tick();
        n_checks++; if (up1.ready !== 1'b1 || up0.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %b/%b want 1/1", up1.ready, up0.ready); end
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h9999; in_ctrl = 8'h01;
        tick(); tick();
        in_valid = 1'b0;
        n_checks++; if (occ1 !== 2'd2) begin n_fail++; $display("[TB] FAIL pre_reset_occ: got %0d want 2", occ1); end
        rst = 1'b0;
        #1;
        n_checks++; if (occ1 !== 2'd0 || dn1.valid !== 1'b0 || dn1.instr !== 16'h0800) begin
            n_fail++; $display("[TB] FAIL async_reset: got occ %0d valid %b instr %h want 0 0 0800", occ1, dn1.valid, dn1.instr);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [15:0]  seq [3];
        logic [127:0] dv [3];
        do_reset();
        seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333;
        for (int i = 0; i < 3; i++) dv[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin in_valid = 1'b1; in_instr = seq[i]; in_data = dv[i]; in_ctrl = 8'hA5; end
            else in_valid = 1'b0;
            #1;
            if (i < 3) begin
                n_checks++; if (up1.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_in_ready[%0d]: got %b want 1", i, up1.ready); end
            end
            if (i > 0) begin
                n_checks++;
                if (dn1.valid !== 1'b1 || dn1.instr !== seq[i-1] || dn1.ctrl !== 8'hA5 || dn1.data !== dv[i-1] || occ1 !== 2'd1) begin
                    n_fail++;
                    $display("[TB] FAIL stream_out[%0d]: got v%b %h %h occ%0d want v1 %h a5 occ1", i, dn1.valid, dn1.instr, dn1.ctrl, occ1, seq[i-1]);
                end
            end
            tick();
        end
        #1;
        n_checks++; if (dn1.valid !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("[TB] FAIL stream_drain: got v%b occ%0d want v0 occ0", dn1.valid, occ1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11;
        in_instr = 16'hAAAA;
        tick();
        in_instr = 16'hBBBB;
        #1;
        n_checks++; if (up1.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_occ1: got %b want 1", up1.ready); end
        tick();
        in_instr = 16'hCCCC;
        tick();
        n_checks++; if (occ1 !== 2'd2 || up1.ready !== 1'b0 || dn1.instr !== 16'hAAAA) begin
            n_fail++; $display("[TB] FAIL bp_full: got occ%0d ready%b %h want occ2 ready0 aaaa", occ1, up1.ready, dn1.instr);
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (dn1.instr !== 16'hBBBB || occ1 !== 2'd1 || up1.ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_drain1: got %h occ%0d ready%b want bbbb occ1 ready1", dn1.instr, occ1, up1.ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++; if (dn1.valid !== 1'b1 || dn1.instr !== 16'hCCCC) begin n_fail++; $display("[TB] FAIL bp_held_entry: got v%b %h want v1 cccc", dn1.valid, dn1.instr); end
        tick();
        n_checks++; if (dn1.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_empty: got %b want 0", dn1.valid); end
    endtask

    task automatic test_bubble();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h4444; in_ctrl = 8'hFF; in_data = {4{32'h0BAD_F00D}};
        bubble = 1'b1;
        #1;
        n_checks++; if (up1.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bubble_ready0: got %b want 0", up1.ready); end
        tick();
        n_checks++; if (up1.ready !== 1'b0 || dn1.instr !== 16'h0800 || dn1.ctrl !== 8'h00 || dn1.valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bubble_out1: got ready%b %h %h v%b want 0 0800 00 1", up1.ready, dn1.instr, dn1.ctrl, dn1.valid);
        end
        tick();
        bubble = 1'b0;
        #1;
        n_checks++; if (dn1.instr !== 16'h0800 || dn1.ctrl !== 8'h00 || stat1 !== 16'd2) begin
            n_fail++; $display("[TB] FAIL bubble_out2: got %h %h stat%0d want 0800 00 stat2", dn1.instr, dn1.ctrl, stat1);
        end
        n_checks++; if (up1.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bubble_release_ready: got %b want 1", up1.ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (dn1.instr !== 16'h4444 || dn1.ctrl !== 8'hFF || stat1 !== 16'd2) begin
            n_fail++; $display("[TB] FAIL bubble_follow: got %h %h stat%0d want 4444 ff stat2", dn1.instr, dn1.ctrl, stat1);
        end
        tick();
    endtask

    task automatic test_flush_bubble();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = {4{32'h1234_5678}};
        in_instr = 16'h5555; tick();
        in_instr = 16'h6666; tick();
        n_checks++; if (occ1 !== 2'd2) begin n_fail++; $display("[TB] FAIL flush_pre_occ: got %0d want 2", occ1); end
        flush = 1'b1; bubble = 1'b1;
        tick();
        n_checks++; if (occ1 !== 2'd0 || dn1.valid !== 1'b0 || dn1.instr !== 16'h0800 || dn1.ctrl !== 8'h00 || dn1.data !== 128'h0) begin
            n_fail++; $display("[TB] FAIL flush_state: got occ%0d v%b %h %h want occ0 v0 0800 00", occ1, dn1.valid, dn1.instr, dn1.ctrl);
        end
        n_checks++; if (stat1 !== 16'd0) begin n_fail++; $display("[TB] FAIL flush_stat: got %0d want 0", stat1); end
        tick();
        n_checks++; if (stat1 !== 16'd0 || occ1 !== 2'd0 || stat0 !== 16'd0) begin
            n_fail++; $display("[TB] FAIL flush_wins: got stat%0d occ%0d stat0 %0d want 0 0 0", stat1, occ1, stat0);
        end
        flush = 1'b0; bubble = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_skid0_saturation();
        do_reset();
        in_valid = 1'b1; in_instr = 16'h7777; in_ctrl = 8'h3C; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (up0.ready !== 1'b0 || dn0.instr !== 16'h7777 || occ0 !== 2'd1) begin
            n_fail++; $display("[TB] FAIL skid0_hold: got ready%b %h occ%0d want 0 7777 1", up0.ready, dn0.instr, occ0);
        end
        n_checks++; if (up1.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL skid1_no_comb: got %b want 1", up1.ready); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (up0.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL skid0_follow_hi: got %b want 1", up0.ready); end
        out_ready = 1'b0;
        #1;
        n_checks++; if (up0.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL skid0_follow_lo: got %b want 0", up0.ready); end
        out_ready = 1'b1; bubble = 1'b1;
        repeat (65534) tick();
        n_checks++; if (stat0 !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL sat_pre: got %h want fffe", stat0); end
        repeat (3) tick();
        n_checks++; if (stat0 !== 16'hFFFF || stat1 !== 16'hFFFF) begin
            n_fail++; $display("[TB] FAIL sat_hold: got %h/%h want ffff/ffff", stat0, stat1);
        end
        bubble = 1'b0;
    endtask

    task automatic test_random();
        logic         a_ready, a_valid;
        logic [1:0]   a_occ;
        logic [15:0]  a_stat, a_instr;
        logic [127:0] a_data;
        logic [7:0]   a_ctrl;
        bit           e_ready;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(9) < 7);
            in_instr  = 16'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_ctrl   = 8'($urandom);
            bubble    = ($urandom_range(9) == 0);
            flush     = ($urandom_range(19) == 0);
            out_ready = ($urandom_range(9) < 6);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (k == 1) begin
                    a_ready = up1.ready; a_valid = dn1.valid; a_occ = occ1; a_stat = stat1;
                    a_instr = dn1.instr; a_data = dn1.data; a_ctrl = dn1.ctrl;
                end else begin
                    a_ready = up0.ready; a_valid = dn0.valid; a_occ = occ0; a_stat = stat0;
                    a_instr = dn0.instr; a_data = dn0.data; a_ctrl = dn0.ctrl;
                end
                e_ready = !bubble && !flush && m_space(k);
                n_checks++; if (a_ready !== e_ready) begin n_fail++; $display("[TB] FAIL rnd_ready skid%0d cyc%0d: got %b want %b", k, c, a_ready, e_ready); end
                n_checks++; if (a_valid !== (msz[k] != 0) || a_occ !== 2'(msz[k])) begin
                    n_fail++; $display("[TB] FAIL rnd_occ skid%0d cyc%0d: got v%b occ%0d want occ%0d", k, c, a_valid, a_occ, msz[k]);
                end
                n_checks++; if (a_stat !== 16'(mcnt[k])) begin n_fail++; $display("[TB] FAIL rnd_stat skid%0d cyc%0d: got %0d want %0d", k, c, a_stat, mcnt[k]); end
                if (msz[k] != 0) begin
                    n_checks++;
                    if (a_instr !== mq[k][0].instr || a_data !== mq[k][0].data || a_ctrl !== mq[k][0].ctrl) begin
                        n_fail++; $display("[TB] FAIL rnd_head skid%0d cyc%0d: got %h/%h want %h/%h", k, c, a_instr, a_ctrl, mq[k][0].instr, mq[k][0].ctrl);
                    end
                end
            end
            model_step();
            tick();
        end
        in_valid = 1'b0; bubble = 1'b0; flush = 1'b0;
    endtask

    // Scenario sequence and final summary.
    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = 16'h0; in_data = '0; in_ctrl = 8'h0;
        for (int k = 0; k < 2; k++) begin msz[k] = 0; mcnt[k] = 0; end
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush_bubble();
        test_random();
        test_skid0_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised successor to the fixed inter-stage pipeline latches: a single pipeline stage with a valid/ready handshake, an optional 2-entry skid buffer, and NOP-bubble injection and flush.
- Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries the instruction word, an opaque data payload, and a control-bit vector.
- Control bits are zeroed and the instruction is forced to NOP whenever a bubble is inserted, so a bubble performs no write, memory access, halt, siic or rti.

Parameters:
- INSTR_W, 16, instruction field width.
- DATA_W, 128, payload width: PC, operands, extended immediates. Carried unmodified.
- CTRL_W, 8, control-bit vector width: memWrite, memtoreg, regWrite, halt, siic, rti, etc. Forced to 0 in bubbles.
- NOP_INSTR, 16'h0800, instruction value written for bubbles and on reset/flush.
- SKID, 1, 0 = single register; 1 = two-entry skid buffer (registered in_ready).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts the upstream entry this cycle.
- in_instr  in  INSTR_W  upstream instruction.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- bubble  in  1  hazard stall: enqueue a NOP bubble instead of the upstream entry.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts the output entry.
- out_instr  out  INSTR_W  head instruction.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control bits.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stat_bubbles  out  16  count of bubbles enqueued, saturating.

Behaviour:
- Reset (rst=0, async) values:
  - out_valid=0, out_instr=NOP_INSTR, out_ctrl=0, out_data=0.
  - occupancy=0, stat_bubbles=0.
  - in_ready=0 while rst is low; 1 from the first clock after release.
- Dequeue: occurs on out_valid & out_ready. Outputs come only from the head register; no combinational path from in_* to out_*.
- Enqueue source, per cycle:
  - bubble=1: entry = {NOP_INSTR, in_data, CTRL 0}. in_ready is forced to 0, so the upstream entry is held, not consumed. The bubble is enqueued whenever space exists, independent of in_valid.
  - bubble=0: entry = {in_instr, in_data, in_ctrl}, enqueued on in_valid & in_ready.
- SKID=0:
  - in_ready = !bubble & !flush & (!out_valid | out_ready). This is a combinational ready path.
  - Enqueue and dequeue in the same cycle replaces the head.
- SKID=1:
  - in_ready = !bubble & !flush & (occupancy<2). occupancy is registered, so there is no combinational dependence on out_ready.
  - Enqueue goes to the head if the head is empty or dequeued this cycle; otherwise to the skid slot.
  - On dequeue with skid occupied, the skid entry moves to the head.
  - FIFO order is always preserved.
  - Simultaneous enqueue and dequeue at occupancy 2 is not possible (in_ready=0).
  - At occupancy 1, simultaneous enqueue and dequeue leaves occupancy at 1.
- Flush (highest priority, synchronous):
  - Next cycle: occupancy=0, out_valid=0, head and skid set to {NOP_INSTR, 0, 0}.
  - No enqueue and no counted bubble in the flush cycle. Any dequeue in that cycle still completes downstream.
- bubble and flush together: flush wins; stat_bubbles does not increment.
- stat_bubbles: +1 per bubble actually enqueued (space available). Saturates at 16'hFFFF and holds. Cleared only by reset.
- Reset mid-transfer: all entries are lost immediately. Outputs take reset values asynchronously.

Test Plan:
- Reset: hold rst=0 with random inputs → out_valid=0, out_instr=16'h0800, out_ctrl=0, occupancy=0, stat_bubbles=0. After release, in_ready=1 next cycle.
- Streaming, SKID=1, out_ready=1: send instrs 16'h1111, 16'h2222, 16'h3333 on consecutive cycles with in_ctrl=8'hA5 → same values appear in order, 1-cycle latency, ctrl=8'hA5, occupancy stays 1.
- Backpressure, SKID=1: out_ready=0, offer 16'hAAAA then 16'hBBBB → occupancy=2, in_ready=0, third entry held upstream. Then out_ready=1 → AAAA then BBBB on consecutive cycles; in_ready returns to 1 with occupancy 1.
- Bubble: in_valid=1, in_instr=16'h4444, in_ctrl=8'hFF, bubble=1 for 2 cycles, out_ready=1 → two outputs with instr=16'h0800, ctrl=0; in_ready=0 throughout; stat_bubbles=2. Then 16'h4444 with ctrl=8'hFF follows.
- Flush with bubble, SKID=1: occupancy=2, assert flush and bubble together → next cycle occupancy=0, out_valid=0, out_instr=16'h0800, stat_bubbles unchanged.
- SKID=0 plus saturation: out_valid=1, out_ready toggled → in_ready follows out_ready combinationally in the same cycle. Force 65537 bubbles → stat_bubbles=16'hFFFF.
